qea_state_reader: RTL and testbench

Readout engine for the QEA state RAM. Once QEA asserts `o_complete`, it sweeps the state RAM port that the host otherwise drives. For each address it captures the `PE_NUM`-lane word and serializes it into one 64-bit complex amplitude per valid/ready handshake, tagged with its basis-state index. It sits between QEA's `i_state_*`/`o_state_dout` port and the host/DMA side, and replaces the manual readout loop used in simulation.

---
 rtl/qea_state_reader.sv | 212 +++++++++++++++++++++
 tb/tb_qea_state_reader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qea_state_reader.sv
`timescale 1ns/1ps
// Sweeps the QEA state RAM after completion and streams one amplitude per handshake; QEA_RDR_CLEAR_EN adds write-back of |0>.
// First amplitude RD_LATENCY+2 cycles after start; output data/idx/last hold while valid is stalled by i_amp_ready.
module qea_state_reader #(
    parameter int PE_NUM_WIDTH     = 2,
    parameter int PE_NUM           = 4,
    parameter int STATE_DATA_WIDTH = 64,
    parameter int STATE_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH   = 6,
    parameter int RD_LATENCY       = 1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     i_start,
    input  logic [MAX_QBIT_WIDTH-1:0]                i_qbit_num,
    output logic                                     o_state_ena,
    output logic                                     o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]              o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]       o_state_dina,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]       i_state_dout,
    output logic                                     o_amp_valid,
    input  logic                                     i_amp_ready,
    output logic [STATE_DATA_WIDTH-1:0]              o_amp_data,
    output logic [STATE_ADDR_WIDTH+PE_NUM_WIDTH-1:0] o_amp_idx,
    output logic                                     o_amp_last,
    output logic                                     o_busy,
    output logic                                     o_done,
    output logic                                     o_err
);

    localparam int WORD_W = PE_NUM * STATE_DATA_WIDTH;
    localparam int IDX_W  = STATE_ADDR_WIDTH + PE_NUM_WIDTH;
    localparam int CNT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [MAX_QBIT_WIDTH-1:0]   Q_MAX    = MAX_QBIT_WIDTH'(IDX_W);
    localparam logic [MAX_QBIT_WIDTH-1:0]   Q_PW     = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
    localparam logic [STATE_ADDR_WIDTH-1:0] ALL_A    = {STATE_ADDR_WIDTH{1'b1}};
    localparam logic [PE_NUM_WIDTH-1:0]     ALL_L    = {PE_NUM_WIDTH{1'b1}};
    localparam logic [CNT_W-1:0]            CNT_LAST = CNT_W'(RD_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_STREAM
    } state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [STATE_ADDR_WIDTH-1:0] r_addr;
    logic [STATE_ADDR_WIDTH-1:0] r_last_addr;
    logic [PE_NUM_WIDTH-1:0]     r_lane;
    logic [PE_NUM_WIDTH-1:0]     r_last_lane;
    logic [CNT_W-1:0]            r_cnt;
    logic [WORD_W-1:0]           r_buf;
    logic                        r_done;
    logic                        r_err;
`ifdef QEA_RDR_CLEAR_EN
    logic                        r_first;
`endif

    logic                        w_q_ok;
    logic [STATE_ADDR_WIDTH-1:0] w_start_last_addr;
    logic [PE_NUM_WIDTH-1:0]     w_start_last_lane;
    logic                        w_hs;
    logic                        w_lane_end;
    logic                        w_word_end;
    logic                        w_wait_end;
    logic [STATE_DATA_WIDTH-1:0] w_lanes [PE_NUM];

    // Sweep extent from the qubit count: shifting all-ones past the width yields the full mask at max q.
    always_comb begin
        w_q_ok            = (i_qbit_num <= Q_MAX);
        w_start_last_addr = '0;
        w_start_last_lane = '0;
        if (i_qbit_num >= Q_PW) begin
            w_start_last_addr = ~(ALL_A << (i_qbit_num - Q_PW));
            w_start_last_lane = ALL_L;
        end else begin
            w_start_last_lane = ~(ALL_L << i_qbit_num);
        end
    end

    always_comb begin
        for (int i = 0; i < PE_NUM; i++) begin
            w_lanes[i] = r_buf[(PE_NUM-1-i)*STATE_DATA_WIDTH +: STATE_DATA_WIDTH];
        end
    end

    assign w_hs       = (r_state == S_STREAM) && i_amp_ready;
    assign w_lane_end = (r_lane == r_last_lane);
    assign w_word_end = (r_addr == r_last_addr);
    assign w_wait_end = (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        o_amp_valid   = 1'b0;
        o_amp_data    = '0;
        o_amp_idx     = '0;
        o_amp_last    = 1'b0;
        o_state_ena   = 1'b0;
        o_state_wea   = 1'b0;
        o_state_addra = '0;
        o_state_dina  = '0;
        case (r_state)
            S_IDLE: begin
                if (i_start && w_q_ok) w_next = S_READ;
            end
            S_READ: begin
                o_state_ena   = 1'b1;
                o_state_addra = r_addr;
                w_next        = S_WAIT;
            end
            S_WAIT: begin
                if (w_wait_end) w_next = S_STREAM;
            end
            S_STREAM: begin
                o_amp_valid = 1'b1;
                o_amp_data  = w_lanes[r_lane];
                o_amp_idx   = {r_addr, r_lane};
                o_amp_last  = w_lane_end && w_word_end;
                if (w_hs && w_lane_end) w_next = w_word_end ? S_IDLE : S_READ;
`ifdef QEA_RDR_CLEAR_EN
                // Word is already in r_buf, so it can be overwritten with the |0> init state.
                if (r_first) begin
                    o_state_ena   = 1'b1;
                    o_state_wea   = 1'b1;
                    o_state_addra = r_addr;
                    if (r_addr == '0) begin
                        o_state_dina[WORD_W-1 -: STATE_DATA_WIDTH] =
                            {2'b01, {(STATE_DATA_WIDTH-2){1'b0}}};
                    end
                end
`endif
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_last_addr <= '0;
            r_lane      <= '0;
            r_last_lane <= '0;
            r_cnt       <= '0;
            r_buf       <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
`ifdef QEA_RDR_CLEAR_EN
            r_first     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (w_q_ok) begin
                            r_addr      <= '0;
                            r_lane      <= '0;
                            r_last_addr <= w_start_last_addr;
                            r_last_lane <= w_start_last_lane;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    r_cnt <= '0;
                end
                S_WAIT: begin
                    if (w_wait_end) begin
                        r_buf <= i_state_dout;
`ifdef QEA_RDR_CLEAR_EN
                        r_first <= 1'b1;
`endif
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_STREAM: begin
`ifdef QEA_RDR_CLEAR_EN
                    r_first <= 1'b0;
`endif
                    if (w_hs) begin
                        if (w_lane_end) begin
                            r_lane <= '0;
                            if (w_word_end) r_done <= 1'b1;
                            else            r_addr <= r_addr + STATE_ADDR_WIDTH'(1);
                        end else begin
                            r_lane <= r_lane + PE_NUM_WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (r_state != S_IDLE);
    assign o_done = r_done;
    assign o_err  = r_err;

endmodule

// File: tb/tb_qea_state_reader.sv
`timescale 1ns/1ps
// Randomized bench for qea_state_reader: RAM model plus an index-ordered reference of the expected amplitude stream.
module tb_qea_state_reader;

    localparam int PW    = 2;
    localparam int PN    = 4;
    localparam int DW    = 64;
    localparam int AW    = 16;
    localparam int QW    = 6;
    localparam int IW    = AW + PW;
    localparam int WW    = PN * DW;
    localparam int DEPTH = 4096;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [QW-1:0] i_qbit_num = '0;
    logic          o_state_ena, o_state_wea;
    logic [AW-1:0] o_state_addra;
    logic [WW-1:0] o_state_dina;
    logic [WW-1:0] ram_dout;
    logic          o_amp_valid;
    logic          i_amp_ready = 1'b0;
    logic [DW-1:0] o_amp_data;
    logic [IW-1:0] o_amp_idx;
    logic          o_amp_last, o_busy, o_done, o_err;

    always #5 clk = ~clk;

    qea_state_reader dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_qbit_num(i_qbit_num),
        .o_state_ena(o_state_ena), .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
        .o_state_dina(o_state_dina), .i_state_dout(ram_dout),
        .o_amp_valid(o_amp_valid), .i_amp_ready(i_amp_ready), .o_amp_data(o_amp_data),
        .o_amp_idx(o_amp_idx), .o_amp_last(o_amp_last), .o_busy(o_busy), .o_done(o_done),
        .o_err(o_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // State RAM with one-cycle read latency; bulk fills happen inside this process.
    logic [WW-1:0] mem   [DEPTH];
    logic [WW-1:0] model [DEPTH];
    logic          fill_req = 1'b0;
    int            fill_kind = 0;

    function automatic logic [WW-1:0] pattern(input int kind, input int w);
        logic [WW-1:0] r;
        logic [DW-1:0] v;
        r = '0;
        for (int l = 0; l < PN; l++) begin
            case (kind)
                0:       v = (w == 0 && l == 0) ? 64'h40000000_00000000 : 64'h0;
                1:       v = {8'hA5, 24'(w * PN + l), ~32'(w * PN + l)};
                default: v = {$urandom, $urandom};
            endcase
            r[(PN-1-l)*DW +: DW] = v;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (fill_req) begin
            for (int w = 0; w < DEPTH; w++) mem[w] <= pattern(fill_kind, w);
        end else if (o_state_ena) begin
            if (o_state_wea) mem[o_state_addra[11:0]] <= o_state_dina;
            ram_dout <= mem[o_state_addra[11:0]];
        end
    end

    task automatic fill(input int kind);
        @(negedge clk);
        fill_kind = kind;
        fill_req  = 1'b1;
        @(negedge clk);
        fill_req  = 1'b0;
    endtask

    task automatic snap();
        for (int w = 0; w < DEPTH; w++) model[w] = mem[w];
    endtask

    task automatic init_model();
        for (int w = 0; w < DEPTH; w++) model[w] = '0;
        model[0][WW-1 -: DW] = 64'h40000000_00000000;
    endtask

    function automatic logic [DW-1:0] exp_amp(input int idx);
        logic [WW-1:0] t;
        t = model[idx / PN] >> ((PN - 1 - (idx % PN)) * DW);
        return t[DW-1:0];
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, "_ena"},   64'(o_state_ena), 64'd0);
        chk({tag, "_wea"},   64'(o_state_wea), 64'd0);
        chk({tag, "_addr"},  64'(o_state_addra), 64'd0);
        chk({tag, "_dina"},  64'(o_state_dina != '0), 64'd0);
        chk({tag, "_valid"}, 64'(o_amp_valid), 64'd0);
        chk({tag, "_data"},  o_amp_data, 64'd0);
        chk({tag, "_idx"},   64'(o_amp_idx), 64'd0);
        chk({tag, "_last"},  64'(o_amp_last), 64'd0);
        chk({tag, "_busy"},  64'(o_busy), 64'd0);
        chk({tag, "_done"},  64'(o_done), 64'd0);
        chk({tag, "_err"},   64'(o_err), 64'd0);
    endtask

    // Starts a sweep of 2^q amplitudes and checks the stream against the model, cycle by cycle.
    task automatic run_sweep(input int q, input int ready_pct, input bit chk_lat);
        int n, got, cyc, first, budget, reads, words;
        bit fin, stall, fin_next;
        logic [DW-1:0] s_dat;
        logic [IW-1:0] s_idx;
        logic          s_last;
        n = 1 << q; got = 0; cyc = 0; first = -1; reads = 0;
        words = (q >= PW) ? (1 << (q - PW)) : 1;
        budget = 8 * n + 64;
        fin = 1'b0; stall = 1'b0; fin_next = 1'b0;
        s_dat = '0; s_idx = '0; s_last = 1'b0;
        @(negedge clk);
        i_qbit_num = QW'(q);
        i_start    = 1'b1;
        @(negedge clk);
        i_start    = 1'b0;
        while (!fin && cyc < budget) begin
            cyc++;
            i_amp_ready = ($urandom_range(99) < ready_pct);
            if (o_state_ena && !o_state_wea) reads++;
            if (chk_lat && cyc == 1) begin
                chk("read_ena",  64'(o_state_ena), 64'd1);
                chk("read_wea",  64'(o_state_wea), 64'd0);
                chk("read_addr", 64'(o_state_addra), 64'd0);
            end
            if (fin_next) begin
                chk("done_pulse", 64'(o_done), 64'd1);
                chk("busy_fall",  64'(o_busy), 64'd0);
                chk("valid_end",  64'(o_amp_valid), 64'd0);
                fin = 1'b1;
            end else begin
                chk("no_early_done", 64'(o_done), 64'd0);
                chk("busy_mid",      64'(o_busy), 64'd1);
`ifndef QEA_RDR_CLEAR_EN
                chk("ro_wea", 64'(o_state_wea), 64'd0);
                chk("ro_dina", 64'(o_state_dina != '0), 64'd0);
`endif
                if (stall) begin
                    chk("stall_valid", 64'(o_amp_valid), 64'd1);
                    chk("stall_data",  o_amp_data, s_dat);
                    chk("stall_idx",   64'(o_amp_idx), 64'(s_idx));
                    chk("stall_last",  64'(o_amp_last), 64'(s_last));
                end
                stall = 1'b0;
                if (o_amp_valid) begin
                    if (first < 0) first = cyc;
                    if (i_amp_ready) begin
                        chk("idx",  64'(o_amp_idx), 64'(got));
                        chk("data", o_amp_data, exp_amp(got));
                        chk("last", 64'(o_amp_last), 64'(got == n - 1));
                        got++;
                        fin_next = (got == n);
                    end else begin
                        stall  = 1'b1;
                        s_dat  = o_amp_data;
                        s_idx  = o_amp_idx;
                        s_last = o_amp_last;
                    end
                end
                @(negedge clk);
            end
        end
        i_amp_ready = 1'b0;
        chk("sweep_done", 64'(fin), 64'd1);
        chk("amp_count",  64'(got), 64'(n));
        chk("read_count", 64'(reads), 64'(words));
        if (chk_lat) chk("first_valid_cyc", 64'(first), 64'd3);
    endtask

    initial begin
        int hs;
        // Reset held with start asserted: nothing may move.
        rst_n      = 1'b0;
        i_start    = 1'b1;
        i_qbit_num = QW'(3);
        repeat (3) begin
            @(negedge clk);
            chk_quiet("rst");
        end
        i_start = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
        chk_quiet("idle");

        fill(0); snap();
        run_sweep(14, 100, 1'b1);

        fill(1); snap();
        run_sweep(6, 60, 1'b0);
        snap();
        run_sweep(1, 100, 1'b1);
        snap();
        run_sweep(0, 100, 1'b1);
        snap();
        run_sweep(2, 40, 1'b0);

        // Out-of-range qubit count is rejected.
        @(negedge clk);
        i_qbit_num = QW'(19);
        i_start    = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("err_pulse", 64'(o_err), 64'd1);
        chk("err_busy",  64'(o_busy), 64'd0);
        chk("err_ena",   64'(o_state_ena), 64'd0);
        @(negedge clk);
        chk("err_clear", 64'(o_err), 64'd0);
        chk("err_busy2", 64'(o_busy), 64'd0);
        chk("err_ena2",  64'(o_state_ena), 64'd0);

        // Largest legal qubit count is accepted, then aborted by reset.
        i_qbit_num = QW'(18);
        i_start    = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("q18_err",  64'(o_err), 64'd0);
        chk("q18_busy", 64'(o_busy), 64'd1);
        chk("q18_ena",  64'(o_state_ena), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_quiet("q18_rst");

        // Reset in the middle of streaming, then a clean restart.
        fill(1); snap();
        @(negedge clk);
        i_qbit_num  = QW'(10);
        i_start     = 1'b1;
        i_amp_ready = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        hs = 0;
        while (!(o_amp_valid && o_amp_idx >= IW'(21)) && hs < 200) begin
            hs++;
            @(negedge clk);
        end
        chk("mid_reached", 64'(hs < 200), 64'd1);
        rst_n = 1'b0;
        i_amp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_quiet("mid_rst");
        repeat (3) begin
            @(negedge clk);
            chk("mid_no_done", 64'(o_done), 64'd0);
            chk("mid_idle",    64'(o_busy), 64'd0);
        end
        snap();
        run_sweep(10, 70, 1'b0);

        // Dump twice: read-only keeps the contents, clear mode leaves |0>.
        fill(2); snap();
        run_sweep(4, 50, 1'b0);
`ifdef QEA_RDR_CLEAR_EN
        init_model();
`endif
        run_sweep(4, 50, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
